// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   - arb_state_e : access sequencer state (idle, busy with wait states, done/ack)
//   - PORT_PIPE / PORT_AUX : requester indices (pipeline, loader/debug)
//   - Def* : default widths and wait-state count
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } arb_state_e;

  localparam int unsigned PORT_PIPE = 0;
  localparam int unsigned PORT_AUX  = 1;

  localparam int unsigned DefAddrW      = 8;
  localparam int unsigned DefDataW      = 32;
  localparam int unsigned DefWaitCycles = 1;

  // Wait-state counter width; WAIT_CYCLES must fit (0..15).
  localparam int unsigned CntW = 4;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick.
//   req_i    : request per port
//   last_i   : port granted most recently
//   winner_o : selected port (only meaningful when valid_o)
//   valid_o  : at least one request present
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       winner_o,
  output logic       valid_o
);

  always_comb begin
    valid_o  = |req_i;
    winner_o = 1'b0;
    case (req_i)
      2'b01:   winner_o = 1'b0;
      2'b10:   winner_o = 1'b1;
      // Contention: the port that did not go last wins.
      2'b11:   winner_o = ~last_i;
      default: winner_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for a single-port data memory.
// Port 0 is the pipeline memory stage, port 1 the loader/debug requester.
// Each access spends WAIT_CYCLES+1 cycles driving the memory strobes, then
// returns a one-cycle ack with registered read data.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   req_i, we_i              : per-port request / write enable
//   addr0_i, addr1_i         : per-port word address
//   wdata0_i, wdata1_i       : per-port write data
//   ack_o                    : one-cycle completion pulse per port
//   rdata_o                  : read data, held until the next read completes
//   stall_o                  : pipeline hold while port 0 is outstanding
//   mem_read_o, mem_write_o  : memory strobes (never both high)
//   mem_addr_o, mem_wdata_o  : memory address / write data
//   mem_rdata_i              : combinational memory read data
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned WAIT_CYCLES = DefWaitCycles
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [CntW-1:0] WaitCnt = CntW'(WAIT_CYCLES);

  arb_state_e        state_q;
  logic              owner_q;
  logic              last_q;
  logic [CntW-1:0]   cnt_q;
  logic              we_l_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        ack_q;
  logic              mem_read_q;
  logic              mem_write_q;

  logic              winner;
  logic              grant_valid;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_rr_arb2 (
    .req_i    (req_i),
    .last_i   (last_q),
    .winner_o (winner),
    .valid_o  (grant_valid)
  );

  // Request fields of the port that wins this cycle.
  always_comb begin
    sel_we    = we_i[winner];
    sel_addr  = addr0_i;
    sel_wdata = wdata0_i;
    if (winner == 1'(PORT_AUX)) begin
      sel_addr  = addr1_i;
      sel_wdata = wdata1_i;
    end
  end

  // Strobes and ack are registered so they switch exactly on state entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      we_l_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      ack_q       <= 2'b00;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            state_q     <= StBusy;
            owner_q     <= winner;
            last_q      <= winner;
            cnt_q       <= '0;
            we_l_q      <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_read_q  <= ~sel_we;
            mem_write_q <= sel_we;
          end
        end
        StBusy: begin
          if (cnt_q == WaitCnt) begin
            // Last busy edge: the memory commits a write / presents read data.
            if (!we_l_q) begin
              rdata_q <= mem_rdata_i;
            end
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            ack_q       <= owner_q ? 2'b10 : 2'b01;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          ack_q   <= 2'b00;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ack_o       = ack_q;
  assign rdata_o     = rdata_q;
  assign mem_read_o  = mem_read_q;
  assign mem_write_o = mem_write_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  // Combinational so the pipeline freezes in the same cycle it requests.
  assign stall_o = req_i[PORT_PIPE] & ~ack_q[PORT_PIPE];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (WAIT_CYCLES = 1, 0, 2), each with
// its own memory and a timeline model derived from grant cycles.
module tb_dmem_arbiter;

  localparam int NI = 3;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n     [NI];
  logic [1:0]    req       [NI];
  logic [1:0]    we        [NI];
  logic [AW-1:0] addr0     [NI];
  logic [AW-1:0] addr1     [NI];
  logic [DW-1:0] wdata0    [NI];
  logic [DW-1:0] wdata1    [NI];
  logic [1:0]    ack       [NI];
  logic [DW-1:0] rdata     [NI];
  logic          stall     [NI];
  logic          mem_read  [NI];
  logic          mem_write [NI];
  logic [AW-1:0] mem_addr  [NI];
  logic [DW-1:0] mem_wdata [NI];
  logic [DW-1:0] mem_rdata [NI];

  logic [DW-1:0] mem     [NI][256];
  logic [DW-1:0] ref_mem [NI][256];

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar k = 0; k < NI; k++) begin : g_inst
    localparam int W = (k == 0) ? 1 : ((k == 1) ? 0 : 2);

    dmem_arbiter #(
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .WAIT_CYCLES (W)
    ) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n[k]),
      .req_i       (req[k]),
      .we_i        (we[k]),
      .addr0_i     (addr0[k]),
      .addr1_i     (addr1[k]),
      .wdata0_i    (wdata0[k]),
      .wdata1_i    (wdata1[k]),
      .ack_o       (ack[k]),
      .rdata_o     (rdata[k]),
      .stall_o     (stall[k]),
      .mem_read_o  (mem_read[k]),
      .mem_write_o (mem_write[k]),
      .mem_addr_o  (mem_addr[k]),
      .mem_wdata_o (mem_wdata[k]),
      .mem_rdata_i (mem_rdata[k])
    );

    // Memory: word i holds i, except 0x10 holds 0xDEADBEEF.
    initial begin
      for (int i = 0; i < 256; i++) begin
        mem[k][i]     = 32'(i);
        ref_mem[k][i] = 32'(i);
      end
      mem[k][8'h10]     = 32'hDEADBEEF;
      ref_mem[k][8'h10] = 32'hDEADBEEF;
    end

    assign mem_rdata[k] = mem[k][mem_addr[k]];

    always @(posedge clk) begin
      if (mem_write[k]) mem[k][mem_addr[k]] = mem_wdata[k];
    end

    // Model: g is the cycle in which the current access was granted (-1 none).
    // Busy cycles g+1..g+1+W, ack in g+2+W, free again from g+3+W.
    int            cyc, g, own, last;
    bit            lwe;
    logic [AW-1:0] laddr;
    logic [DW-1:0] lwd, exp_rdata;
    bit            busy, ackc;
    logic [1:0]    eack;

    always @(posedge clk or negedge rst_n[k]) begin
      if (!rst_n[k]) begin
        cyc = 0; g = -1; last = 1; own = 0; lwe = 1'b0;
        laddr = '0; lwd = '0; exp_rdata = '0;
      end else begin
        if (g >= 0 && cyc == g + 1 + W) begin
          if (lwe) ref_mem[k][laddr] = lwd;
          else exp_rdata = ref_mem[k][laddr];
        end
        if ((g < 0 || cyc >= g + 3 + W) && req[k] != 2'b00) begin
          if (req[k] == 2'b11) own = 1 - last;
          else own = req[k][1] ? 1 : 0;
          last  = own;
          g     = cyc;
          lwe   = we[k][own];
          laddr = (own == 1) ? addr1[k] : addr0[k];
          lwd   = (own == 1) ? wdata1[k] : wdata0[k];
        end
        cyc++;
      end
    end

    always @(negedge clk) begin
      if (run) begin
        busy = (g >= 0) && (cyc >= g + 1) && (cyc <= g + 1 + W);
        ackc = (g >= 0) && (cyc == g + 2 + W);
        eack = ackc ? ((own == 1) ? 2'b10 : 2'b01) : 2'b00;
        check($sformatf("i%0d ack", k), ack[k], eack);
        check($sformatf("i%0d mem_read", k), mem_read[k], busy && !lwe);
        check($sformatf("i%0d mem_write", k), mem_write[k], busy && lwe);
        check($sformatf("i%0d rdata", k), rdata[k], exp_rdata);
        check($sformatf("i%0d stall", k), stall[k], req[k][0] & ~eack[0]);
        if (busy || g < 0) begin
          check($sformatf("i%0d mem_addr", k), mem_addr[k], busy ? laddr : '0);
          check($sformatf("i%0d mem_wdata", k), mem_wdata[k], busy ? lwd : '0);
        end
      end
    end
  end

  // One access on port p of instance k; lat = cycles from request to ack.
  task automatic access(input int k, input int p, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int lat);
    req[k][p] = 1'b1;
    we[k][p]  = w;
    if (p == 0) begin
      addr0[k] = a; wdata0[k] = d;
    end else begin
      addr1[k] = a; wdata1[k] = d;
    end
    lat = 0;
    forever begin
      @(negedge clk);
      if (ack[k][p]) break;
      lat++;
      if (lat > 40) begin
        checks++; errors++;
        $display("FAIL ack timeout inst %0d port %0d: got no ack required ack", k, p);
        break;
      end
    end
    @(posedge clk); #1;
    req[k][p] = 1'b0;
    we[k][p]  = 1'b0;
  endtask

  task automatic reset_inst(input int k);
    rst_n[k] = 1'b0;
    @(posedge clk); #1;
    rst_n[k] = 1'b1;
  endtask

  initial begin
    int lat, nack, overlap, rcnt;
    int order [6];
    int ackcyc [3];

    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b0; req[k] = '0; we[k] = '0;
      addr0[k] = '0; addr1[k] = '0; wdata0[k] = '0; wdata1[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
    run = 1'b1;

    // Reset state.
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("reset ack", ack[k], 2'b00);
      check("reset mem_read", mem_read[k], 1'b0);
      check("reset mem_write", mem_write[k], 1'b0);
      check("reset mem_addr", mem_addr[k], '0);
      check("reset rdata", rdata[k], '0);
    end
    @(posedge clk); #1;

    // Port 0 read of 0x10, WAIT_CYCLES=1.
    req[0] = 2'b01; we[0] = 2'b00; addr0[0] = 8'h10;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t1 stall", stall[0], c < 3);
      check("t1 mem_read", mem_read[0], c == 1 || c == 2);
      check("t1 ack", ack[0], (c == 3) ? 2'b01 : 2'b00);
      if (c == 3) check("t1 rdata", rdata[0], 32'hDEADBEEF);
      @(posedge clk); #1;
    end
    req[0] = 2'b00;

    // Port 1 write, then port 0 reads it back.
    access(0, 1, 1'b1, 8'h20, 32'h12345678, lat);
    check("t2 write latency", lat, 3);
    check("t2 mem content", mem[0][8'h20], 32'h12345678);
    access(0, 0, 1'b0, 8'h20, '0, lat);
    check("t2 read rdata", rdata[0], 32'h12345678);

    // Both ports saturated from reset.
    reset_inst(0);
    req[0] = 2'b11; we[0] = 2'b00; addr0[0] = 8'h10; addr1[0] = 8'h20;
    nack = 0; overlap = 0;
    for (int c = 0; c < 60 && nack < 6; c++) begin
      @(negedge clk);
      if (mem_read[0] && mem_write[0]) overlap++;
      if (ack[0] != 2'b00 && nack < 6) begin
        order[nack] = ack[0][1] ? 1 : 0;
        nack++;
      end
      @(posedge clk); #1;
    end
    req[0] = 2'b00;
    check("t3 ack count", nack, 6);
    check("t3 strobe overlap", overlap, 0);
    for (int i = 0; i < 6; i++) check($sformatf("t3 grant %0d", i), order[i], i % 2);

    // Port 1 drops req mid-BUSY.
    req[0] = 2'b10; we[0] = 2'b00; addr1[0] = 8'h10;
    @(posedge clk); #1;
    req[0] = 2'b00;
    nack = 0; rcnt = 0;
    for (int c = 1; c < 9; c++) begin
      @(negedge clk);
      if (ack[0][1]) nack++;
      if (mem_read[0]) rcnt++;
      @(posedge clk); #1;
    end
    check("t6 ack1 pulses", nack, 1);
    check("t6 read cycles", rcnt, 2);
    check("t6 rdata", rdata[0], 32'hDEADBEEF);

    // WAIT_CYCLES=0: latency 2, back-to-back period 3.
    access(1, 0, 1'b0, 8'h10, '0, lat);
    check("t4 latency", lat, 2);
    req[1] = 2'b01; addr0[1] = 8'h05;
    nack = 0;
    for (int c = 0; c < 40 && nack < 3; c++) begin
      @(negedge clk);
      if (ack[1][0] && nack < 3) begin
        ackcyc[nack] = c;
        nack++;
      end
      @(posedge clk); #1;
    end
    req[1] = 2'b00;
    check("t4 ack count", nack, 3);
    check("t4 ack cycle 0", ackcyc[0], 2);
    check("t4 ack cycle 1", ackcyc[1], 5);
    check("t4 ack cycle 2", ackcyc[2], 8);

    // WAIT_CYCLES=2: reset during the first BUSY cycle of a write.
    req[2] = 2'b01; we[2] = 2'b01; addr0[2] = 8'h30; wdata0[2] = 32'hCAFEF00D;
    @(posedge clk); #3;
    check("t5 mem_write before reset", mem_write[2], 1'b1);
    rst_n[2] = 1'b0;
    #1;
    check("t5 mem_write in reset", mem_write[2], 1'b0);
    check("t5 mem_read in reset", mem_read[2], 1'b0);
    check("t5 ack in reset", ack[2], 2'b00);
    req[2] = 2'b00; we[2] = 2'b00;
    nack = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack[2] != 2'b00) nack++;
    end
    @(posedge clk); #1;
    rst_n[2] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (ack[2] != 2'b00) nack++;
    end
    check("t5 no ack", nack, 0);
    check("t5 mem unchanged", mem[2][8'h30], 32'h30);
    @(posedge clk); #1;
    access(2, 0, 1'b0, 8'h30, '0, lat);
    check("t5 idle after reset latency", lat, 4);
    check("t5 readback", rdata[2], 32'h30);

    repeat (3) @(posedge clk);
    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
